// File: rtl/shift_add_multiplier.sv
// Iterative unsigned N x N shift-and-add multiplier.
// Retires one multiplier bit per clock and returns a 2N-bit product with a one-cycle done strobe.
module shift_add_multiplier #(
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic [2*N-1:0] product,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CntW = $clog2(N + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*N-1:0]  product_q, product_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2*N-1:0]  acc_next;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    // Cannot wrap: the partial sums are bounded by (2^N-1)^2.
    acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);

    case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d  = {{N{1'b0}}, multiplicand};
          mplier_d = multiplier;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StCalc;
          busy_d   = 1'b1;
        end
      end
      StCalc: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        busy_d   = 1'b1;
        if (cnt_q == CntLast) begin
          state_d   = StDone;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          product_d = acc_next;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product = product_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: an N=4 instance and an N=8 instance on one clock.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [7:0]  prod4;
  logic        busy4, done4;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [15:0] prod8;
  logic        busy8, done8;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_add_multiplier #(.N(4)) u_dut4 (
    .clk         (clk),
    .rst         (rst),
    .start       (start4),
    .multiplicand(a4),
    .multiplier  (b4),
    .product     (prod4),
    .busy        (busy4),
    .done        (done4)
  );

  shift_add_multiplier #(.N(8)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .start       (start8),
    .multiplicand(a8),
    .multiplier  (b8),
    .product     (prod8),
    .busy        (busy8),
    .done        (done8)
  );

  // Advance past the next rising edge; inputs are driven and outputs sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd5;
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    step();
    step();
    total++;
    if ({busy4, done4, prod4} !== 10'h000) begin
      bad++;
      $display("FAIL reset_n4: got busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    total++;
    if ({busy8, done8, prod8} !== 18'h0) begin
      bad++;
      $display("FAIL reset_n8: got busy=%b done=%b product=%h, want 0 0 0000", busy8, done8, prod8);
    end
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;
    step();
    total++;
    if ({busy4, busy8} !== 2'b00) begin
      bad++;
      $display("FAIL reset_no_start: got busy4=%b busy8=%b, want 0 0", busy4, busy8);
    end
  endtask

  task automatic test_basic();
    logic [3:0] ta [3] = '{4'd3, 4'd15, 4'd0};
    logic [3:0] tb [3] = '{4'd5, 4'd15, 4'd9};
    logic [7:0] te [3] = '{8'h0F, 8'hE1, 8'h00};
    logic [7:0] prev = 8'h00;
    for (int v = 0; v < 3; v++) begin
      a4 = ta[v]; b4 = tb[v]; start4 = 1'b1;
      step();
      start4 = 1'b0;
      // Cycles k+1..k+4: busy, no done, old product held.
      for (int i = 0; i < 4; i++) begin
        total++;
        if ({busy4, done4, prod4} !== {2'b10, prev}) begin
          bad++;
          $display("FAIL basic_calc v%0d c%0d: got busy=%b done=%b product=%h, want 1 0 %h",
                   v, i + 1, busy4, done4, prod4, prev);
        end
        step();
      end
      total++;
      if ({busy4, done4, prod4} !== {2'b01, te[v]}) begin
        bad++;
        $display("FAIL basic_done v%0d: got busy=%b done=%b product=%h, want 0 1 %h",
                 v, busy4, done4, prod4, te[v]);
      end
      step();
      total++;
      if ({busy4, done4, prod4} !== {2'b00, te[v]}) begin
        bad++;
        $display("FAIL basic_idle v%0d: got busy=%b done=%b product=%h, want 0 0 %h",
                 v, busy4, done4, prod4, te[v]);
      end
      prev = te[v];
    end
  endtask

  task automatic test_ignored_start();
    int ndone = 0;
    int nbusy = 0;
    logic [7:0] got = 8'h00;
    a4 = 4'd7; b4 = 4'd6; start4 = 1'b1;
    step();
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    step();
    start4 = 1'b1; a4 = 4'd2; b4 = 4'd2;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done4) begin
        ndone++;
        got = prod4;
      end
      if (busy4) nbusy++;
      step();
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("FAIL ignored_done_count: got %0d done pulses, want 1", ndone);
    end
    total++;
    if (got !== 8'd42) begin
      bad++;
      $display("FAIL ignored_product: got %0d, want 42", got);
    end
    total++;
    if (nbusy != 2) begin
      bad++;
      $display("FAIL ignored_busy_cycles: got %0d busy cycles, want 2", nbusy);
    end
  endtask

  task automatic test_reset_midop();
    int ndone = 0;
    int lat = 0;
    a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    step();
    start4 = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if ({busy4, done4, prod4} !== 10'h000) begin
      bad++;
      $display("FAIL midop_reset: got busy=%b done=%b product=%h, want 0 0 00", busy4, done4, prod4);
    end
    for (int i = 0; i < 8; i++) begin
      if (done4 || busy4) ndone++;
      step();
    end
    total++;
    if (ndone != 0) begin
      bad++;
      $display("FAIL midop_abandoned: got %0d busy/done cycles after reset, want 0", ndone);
    end
    a4 = 4'd4; b4 = 4'd3; start4 = 1'b1;
    step();
    start4 = 1'b0;
    lat = 1;
    while (!done4 && lat < 20) begin
      step();
      lat++;
    end
    total++;
    if (lat != 5) begin
      bad++;
      $display("FAIL midop_latency: got done %0d cycles after start, want 5", lat);
    end
    total++;
    if (prod4 !== 8'd12) begin
      bad++;
      $display("FAIL midop_product: got %0d, want 12", prod4);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 1;
    int nres = 0;
    int t [2] = '{0, 0};
    logic [15:0] p [2] = '{16'h0, 16'h0};
    a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    step();
    a8 = 8'd16; b8 = 8'd16;
    while (nres < 2 && cyc < 40) begin
      if (done8) begin
        p[nres] = prod8;
        t[nres] = cyc;
        nres++;
        if (nres == 2) start8 = 1'b0;
      end
      if (nres < 2) begin
        step();
        cyc++;
      end
    end
    start8 = 1'b0;
    total++;
    if (nres != 2) begin
      bad++;
      $display("FAIL b2b_results: got %0d results within bound, want 2", nres);
    end
    total++;
    if (p[0] !== 16'd65025) begin
      bad++;
      $display("FAIL b2b_first: got %0d, want 65025", p[0]);
    end
    total++;
    if (p[1] !== 16'd256) begin
      bad++;
      $display("FAIL b2b_second: got %0d, want 256", p[1]);
    end
    total++;
    if (t[0] != 9) begin
      bad++;
      $display("FAIL b2b_latency: got done %0d cycles after start, want 9", t[0]);
    end
    total++;
    if (t[1] - t[0] != 10) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d cycles between done pulses, want 10", t[1] - t[0]);
    end
    total++;
    if ((p[0] / 16'd255 != 16'd255) || (p[0] % 16'd255 != 16'd0)) begin
      bad++;
      $display("FAIL b2b_divide: got %0d/255=%0d rem %0d, want 255 rem 0",
               p[0], p[0] / 16'd255, p[0] % 16'd255);
    end
    step();
    step();
    total++;
    if ({busy8, done8} !== 2'b00) begin
      bad++;
      $display("FAIL b2b_stop: got busy=%b done=%b after start dropped, want 0 0", busy8, done8);
    end
  endtask

  initial begin
    step();
    test_reset();
    test_basic();
    test_ignored_start();
    test_reset_midop();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
- Sequential unsigned N×N multiplier using the shift-and-add method; the multiplicative counterpart of the lab's combinational divider.
- Accepts a start pulse with two operands, iterates one multiplier bit per clock, and presents a 2N-bit product with a one-cycle done strobe.
- Used in lab datapaths where a compact iterative multiplier is preferred over an array multiplier.
- Its outputs are directly checkable against the divider: product / multiplier = multiplicand, remainder 0.

Parameters:
- N, 4, operand width in bits (N ≥ 2); product width is 2N.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a multiplication; sampled only in IDLE.
- multiplicand  input  N  unsigned operand A; sampled together with start.
- multiplier  input  N  unsigned operand B; sampled together with start.
- product  output  2N  unsigned A×B; registered; holds its value until the next result.
- busy  output  1  high while an operation is in progress (CALC state).
- done  output  1  one-cycle strobe; product is valid in the same cycle.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst. rst=1 at a rising edge forces the following, with priority over all other inputs:
  - state=IDLE
  - product=0, busy=0, done=0
  - internal accumulator, shifted-multiplicand register, multiplier shift register and bit counter all cleared.
- State machine:
  - IDLE, CALC and DONE.
  - Registered outputs: busy=1 exactly in CALC; done=1 exactly in DONE.
- IDLE:
  - start=1 at edge k: latch A into a 2N-bit register, zero-extended.
  - Latch B into an N-bit shift register.
  - Clear the accumulator and the counter; next state CALC.
  - start=0: stay in IDLE.
- CALC, one iteration per edge:
  - If the shift register LSB is 1, the accumulator is incremented by the shifted multiplicand, modulo 2^(2N); the sum never actually overflows.
  - The shifted multiplicand shifts left by 1; the multiplier register shifts right by 1; the counter increments.
  - After exactly N iterations: next state DONE, and product is loaded with the final accumulator on that same edge.
- DONE: lasts exactly one cycle, then unconditionally returns to IDLE.
- Latency: start sampled at edge k gives:
  - busy=1 during cycles k+1 .. k+N
  - done=1 and new product visible during cycle k+N+1
  - IDLE again at k+N+2.
- Latency is fixed at N+1 cycles regardless of operand values. There is no early termination for zero or small operands.
- product:
  - changes only on the edge entering DONE, or on reset;
  - keeps the previous result throughout a subsequent CALC.
- start while in CALC or DONE is ignored. Operand changes after the sampling edge have no effect.
- Back-to-back: start held high continuously is accepted again in the first IDLE cycle after DONE, giving a throughput of one result per N+2 cycles.
- Reset mid-operation (during CALC or DONE): the operation is abandoned, no done strobe is produced, and product reads 0.
- Arithmetic: purely unsigned. Maximum result (2^N−1)^2 fits in 2N bits; for N=4 this is 225 = 0xE1.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 → product=0x00, busy=0, done=0; no operation starts while rst=1.
- N=4, A=3, B=5, start pulse at edge k → busy high cycles k+1..k+4; done=1 only in cycle k+5 with product=15 (0x0F); IDLE at k+6.
- N=4, A=15, B=15 → product=225 (0xE1). Then A=0, B=9 → product=0, with done still exactly 5 cycles after start.
- Ignored start: start A=7, B=6; in the second CALC cycle assert start with A=2, B=2 → single done, product=42; no second operation begins.
- Reset mid-op: start A=9, B=9; assert rst in the third CALC cycle → no done strobe, product=0, busy=0; a following start with A=4, B=3 gives product=12.
- N=8 instance, start held high with A=255, B=255, then A=16, B=16 → products 65025 then 256, with done pulses 10 cycles apart. Cross-check each result against the divider: 65025/255 = 255, remainder 0.
